// File: rtl/cfg_frame_loader_if.sv
// Host byte link plus config-register write port of the frame loader.
// The master side is the byte source and the observer of the write port.
interface cfg_frame_loader_if;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        cfg_we;
    logic [3:0]  cfg_addr;
    logic [15:0] wght_data;
    logic        frame_err;
    logic [7:0]  err_cnt;
    logic        busy;

    modport master (
        output rx_valid, rx_data,
        input  rx_ready, cfg_we, cfg_addr, wght_data, frame_err, err_cnt, busy
    );

    modport slave (
        input  rx_valid, rx_data,
        output rx_ready, cfg_we, cfg_addr, wght_data, frame_err, err_cnt, busy
    );
endinterface

// File: rtl/cfg_frame_loader.sv
// Parses 0xA5|addr|data_hi|data_lo|csum frames from a byte stream and issues
// one config-register write per good frame; bad or stalled frames are counted.
module cfg_frame_loader #(
    parameter logic [7:0] SYNC_BYTE   = 8'hA5,
    parameter logic [3:0] MAX_ADDR    = 4'h5,
    parameter int         TIMEOUT_CYC = 1000
) (
    input logic               clk,
    input logic               rst,
    cfg_frame_loader_if.slave bus
);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [2:0] {IDLE, ADDR, DHI, DLO, CSUM, WRITE} state_t;

    state_t        state;
    state_t        state_next;
    logic [TW-1:0] idle_cnt;
    logic [TW-1:0] idle_cnt_next;
    logic [7:0]    addr_byte;
    logic [7:0]    dhi_byte;
    logic [7:0]    dlo_byte;
    logic [3:0]    cfg_addr;
    logic [15:0]   wght_data;
    logic          frame_err;
    logic [7:0]    err_cnt;
    logic          ready;
    logic          accept;
    logic          in_frame;
    logic          frame_good;
    logic          timeout;
    logic          reject;
    logic          commit;

    assign ready    = (state != WRITE);
    assign accept   = bus.rx_valid && ready;
    assign in_frame = (state == ADDR) || (state == DHI) || (state == DLO) || (state == CSUM);

    // The checksum byte is judged as it arrives, against the three stored bytes.
    assign frame_good = (bus.rx_data == (addr_byte ^ dhi_byte ^ dlo_byte)) &&
                        (addr_byte[7:4] == 4'h0) &&
                        (addr_byte[3:0] <= MAX_ADDR);
    assign timeout = in_frame && !accept && (idle_cnt == TW'(TIMEOUT_CYC - 1));
    assign reject  = ((state == CSUM) && accept && !frame_good) || timeout;
    assign commit  = (state == CSUM) && accept && frame_good;

    always_comb begin
        state_next    = state;
        idle_cnt_next = '0;
        case (state)
            IDLE:    if (accept && (bus.rx_data == SYNC_BYTE)) state_next = ADDR;
            ADDR:    if (accept) state_next = DHI;
            DHI:     if (accept) state_next = DLO;
            DLO:     if (accept) state_next = CSUM;
            CSUM:    if (accept) state_next = frame_good ? WRITE : IDLE;
            WRITE:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (in_frame && !accept) begin
            if (timeout) state_next = IDLE;
            else         idle_cnt_next = idle_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            idle_cnt  <= '0;
            cfg_addr  <= '0;
            wght_data <= '0;
            frame_err <= 1'b0;
            err_cnt   <= '0;
        end else begin
            state     <= state_next;
            idle_cnt  <= idle_cnt_next;
            frame_err <= reject;
            if (reject && (err_cnt != 8'hFF)) err_cnt <= err_cnt + 1'b1;
            // Write port values change only on a committed frame and then hold.
            if (commit) begin
                cfg_addr  <= addr_byte[3:0];
                wght_data <= {dhi_byte, dlo_byte};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            case (state)
                ADDR:    addr_byte <= bus.rx_data;
                DHI:     dhi_byte  <= bus.rx_data;
                DLO:     dlo_byte  <= bus.rx_data;
                default: ;
            endcase
        end
    end

    assign bus.rx_ready  = ready;
    assign bus.cfg_we    = (state == WRITE);
    assign bus.cfg_addr  = cfg_addr;
    assign bus.wght_data = wght_data;
    assign bus.frame_err = frame_err;
    assign bus.err_cnt   = err_cnt;
    assign bus.busy      = (state != IDLE);
endmodule

// File: tb/tb_cfg_frame_loader.sv
// Bench for cfg_frame_loader: directed frames plus randomized streams checked
// against a queue-based frame parser model.
module tb_cfg_frame_loader;
    localparam int TMO = 1000;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cfg_frame_loader_if bus ();

    cfg_frame_loader #(
        .SYNC_BYTE  (8'hA5),
        .MAX_ADDR   (4'h5),
        .TIMEOUT_CYC(TMO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int acc_cyc;
    always @(posedge clk) cyc <= cyc + 1;

    // Observed write strobes and error pulses, stamped with the cycle index.
    logic [3:0]  mon_addr[$];
    logic [15:0] mon_data[$];
    int          mon_we_cyc[$];
    int          mon_err_cyc[$];
    bit          both_seen = 0;
    bit          ready_bad = 0;

    always @(negedge clk) begin
        if (bus.cfg_we === 1'b1) begin
            mon_addr.push_back(bus.cfg_addr);
            mon_data.push_back(bus.wght_data);
            mon_we_cyc.push_back(cyc);
        end
        if (bus.frame_err === 1'b1) mon_err_cyc.push_back(cyc);
        if (bus.cfg_we === 1'b1 && bus.frame_err === 1'b1) both_seen = 1;
        if (rst === 1'b1 && (bus.rx_ready !== ~bus.cfg_we)) ready_bad = 1;
    end

    // Reference model: collect a frame as a list of accepted bytes.
    logic [7:0]  fb[$];
    logic [3:0]  exp_addr[$];
    logic [15:0] exp_data[$];
    int          exp_we_cyc[$];
    int          exp_err_cyc[$];
    int          exp_errs = 0;

    function automatic void model_feed(input logic [7:0] b, input int at);
        if (fb.size() == 0) begin
            if (b == 8'hA5) fb.push_back(b);
        end else begin
            fb.push_back(b);
            if (fb.size() == 5) begin
                if (fb[4] == (fb[1] ^ fb[2] ^ fb[3]) && fb[1] <= 8'd5) begin
                    exp_addr.push_back(fb[1][3:0]);
                    exp_data.push_back({fb[2], fb[3]});
                    exp_we_cyc.push_back(at);
                end else begin
                    exp_err_cyc.push_back(at);
                    exp_errs++;
                end
                fb.delete();
            end
        end
    endfunction

    function automatic void model_timeout(input int at);
        if (fb.size() != 0) begin
            exp_err_cyc.push_back(at);
            exp_errs++;
            fb.delete();
        end
    endfunction

    function automatic int exp_cnt();
        return (exp_errs > 255) ? 255 : exp_errs;
    endfunction

    function automatic void clear_logs();
        mon_addr.delete(); mon_data.delete(); mon_we_cyc.delete(); mon_err_cyc.delete();
        exp_addr.delete(); exp_data.delete(); exp_we_cyc.delete(); exp_err_cyc.delete();
    endfunction

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    // Present one byte after gap idle cycles and hold it until accepted.
    task automatic send_byte(input logic [7:0] b, input int gap);
        bit r;
        bit done;
        repeat (gap) begin
            bus.rx_valid = 1'b0;
            @(posedge clk);
            @(negedge clk);
        end
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        done = 0;
        for (int t = 0; t < 8 && !done; t++) begin
            r = bus.rx_ready;
            @(posedge clk);
            #1;
            if (r) begin
                done    = 1;
                acc_cyc = cyc;
            end
            @(negedge clk);
        end
        bus.rx_valid = 1'b0;
        total++;
        if (!done) begin
            bad++;
            $display("FAIL accept: byte %02h not taken, rx_ready=%b want 1", b, bus.rx_ready);
        end else begin
            model_feed(b, acc_cyc);
        end
    endtask

    task automatic send_frame(input logic [7:0] b0, b1, b2, b3, b4, input int gap);
        send_byte(b0, gap);
        send_byte(b1, gap);
        send_byte(b2, gap);
        send_byte(b3, gap);
        send_byte(b4, gap);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        repeat (3) @(negedge clk);
        total++;
        if ({bus.rx_ready, bus.cfg_we, bus.cfg_addr, bus.wght_data, bus.frame_err, bus.err_cnt, bus.busy}
            !== {1'b1, 1'b0, 4'h0, 16'h0000, 1'b0, 8'h00, 1'b0}) begin
            bad++;
            $display("FAIL reset_state: rdy=%b we=%b addr=%h data=%h err=%b cnt=%0d busy=%b want 1 0 0 0000 0 0 0",
                     bus.rx_ready, bus.cfg_we, bus.cfg_addr, bus.wght_data, bus.frame_err, bus.err_cnt, bus.busy);
        end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_good_frame();
        clear_logs();
        send_frame(8'hA5, 8'h03, 8'h00, 8'h07, 8'h04, 0);
        idle(3);
        total++;
        if (mon_we_cyc.size() != 1) begin
            bad++; $display("FAIL good_we_count: got %0d want 1", mon_we_cyc.size());
        end else begin
            total++;
            if ({mon_addr[0], mon_data[0]} !== {4'h3, 16'h0007}) begin
                bad++; $display("FAIL good_write: got addr=%h data=%h want 3 0007", mon_addr[0], mon_data[0]);
            end
            total++;
            if (mon_we_cyc[0] != exp_we_cyc[0]) begin
                bad++; $display("FAIL good_latency: got cycle %0d want %0d", mon_we_cyc[0], exp_we_cyc[0]);
            end
        end
        total++;
        if (mon_err_cyc.size() != 0 || bus.err_cnt !== 8'd0) begin
            bad++; $display("FAIL good_no_err: got pulses=%0d cnt=%0d want 0 0", mon_err_cyc.size(), bus.err_cnt);
        end
        total++;
        if ({bus.cfg_we, bus.cfg_addr, bus.wght_data} !== {1'b0, 4'h3, 16'h0007}) begin
            bad++; $display("FAIL good_hold: got we=%b addr=%h data=%h want 0 3 0007", bus.cfg_we, bus.cfg_addr, bus.wght_data);
        end
    endtask

    task automatic test_bad_csum();
        clear_logs();
        send_frame(8'hA5, 8'h04, 8'h00, 8'h64, 8'h61, 0);
        idle(3);
        total++;
        if (mon_we_cyc.size() != 0 || mon_err_cyc.size() != 1) begin
            bad++; $display("FAIL csum_events: got we=%0d err=%0d want 0 1", mon_we_cyc.size(), mon_err_cyc.size());
        end else begin
            total++;
            if (mon_err_cyc[0] != exp_err_cyc[0]) begin
                bad++; $display("FAIL csum_err_cycle: got %0d want %0d", mon_err_cyc[0], exp_err_cyc[0]);
            end
        end
        total++;
        if (bus.err_cnt !== 8'(exp_cnt()) || bus.cfg_addr !== 4'h3) begin
            bad++; $display("FAIL csum_cnt: got cnt=%0d addr=%h want %0d 3", bus.err_cnt, bus.cfg_addr, exp_cnt());
        end
    endtask

    task automatic test_bad_addr();
        clear_logs();
        send_frame(8'hA5, 8'h06, 8'h00, 8'h01, 8'h07, 0);
        send_frame(8'hA5, 8'h12, 8'h00, 8'h01, 8'h13, 0);
        idle(3);
        total++;
        if (mon_we_cyc.size() != 0 || mon_err_cyc.size() != 2) begin
            bad++; $display("FAIL addr_events: got we=%0d err=%0d want 0 2", mon_we_cyc.size(), mon_err_cyc.size());
        end
        total++;
        if (bus.err_cnt !== 8'(exp_cnt())) begin
            bad++; $display("FAIL addr_cnt: got %0d want %0d", bus.err_cnt, exp_cnt());
        end
    endtask

    task automatic test_junk();
        clear_logs();
        send_byte(8'h00, 0);
        send_byte(8'hFF, 1);
        send_byte(8'h5A, 0);
        total++;
        if (bus.busy !== 1'b0) begin
            bad++; $display("FAIL junk_busy: got %b want 0", bus.busy);
        end
        send_frame(8'hA5, 8'h05, 8'h00, 8'hB4, 8'hB1, 1);
        idle(3);
        total++;
        if (mon_we_cyc.size() != 1 || mon_err_cyc.size() != 0) begin
            bad++; $display("FAIL junk_events: got we=%0d err=%0d want 1 0", mon_we_cyc.size(), mon_err_cyc.size());
        end
        total++;
        if ({bus.cfg_addr, bus.wght_data} !== {4'h5, 16'h00B4}) begin
            bad++; $display("FAIL junk_write: got addr=%h data=%h want 5 00b4", bus.cfg_addr, bus.wght_data);
        end
    endtask

    task automatic test_timeout();
        int last;
        clear_logs();
        send_byte(8'hA5, 0);
        send_byte(8'h01, 0);
        last = acc_cyc;
        idle(TMO - 1);
        total++;
        if (bus.busy !== 1'b1 || bus.frame_err !== 1'b0) begin
            bad++; $display("FAIL timeout_early: got busy=%b err=%b want 1 0", bus.busy, bus.frame_err);
        end
        idle(1);
        model_timeout(last + TMO);
        total++;
        if (bus.busy !== 1'b0 || bus.frame_err !== 1'b1 || bus.err_cnt !== 8'(exp_cnt())) begin
            bad++; $display("FAIL timeout_hit: got busy=%b err=%b cnt=%0d want 0 1 %0d",
                            bus.busy, bus.frame_err, bus.err_cnt, exp_cnt());
        end
        send_frame(8'hA5, 8'h02, 8'h12, 8'h34, 8'h24, 0);
        idle(3);
        total++;
        if (mon_we_cyc.size() != 1 || {bus.cfg_addr, bus.wght_data} !== {4'h2, 16'h1234}) begin
            bad++; $display("FAIL timeout_recover: got we=%0d addr=%h data=%h want 1 2 1234",
                            mon_we_cyc.size(), bus.cfg_addr, bus.wght_data);
        end
    endtask

    task automatic test_back_to_back();
        clear_logs();
        send_frame(8'hA5, 8'h00, 8'h11, 8'h22, 8'h33, 0);
        send_frame(8'hA5, 8'h01, 8'hA5, 8'h5A, 8'hFE, 0);
        send_frame(8'hA5, 8'h04, 8'hFF, 8'h00, 8'hFB, 0);
        idle(3);
        total++;
        if (mon_we_cyc.size() != exp_we_cyc.size() || mon_err_cyc.size() != 0) begin
            bad++; $display("FAIL b2b_count: got we=%0d err=%0d want %0d 0",
                            mon_we_cyc.size(), mon_err_cyc.size(), exp_we_cyc.size());
        end
        for (int i = 0; i < exp_we_cyc.size() && i < mon_we_cyc.size(); i++) begin
            total++;
            if ({mon_addr[i], mon_data[i], mon_we_cyc[i]} !== {exp_addr[i], exp_data[i], exp_we_cyc[i]}) begin
                bad++; $display("FAIL b2b_write%0d: got %h/%h@%0d want %h/%h@%0d", i,
                                mon_addr[i], mon_data[i], mon_we_cyc[i], exp_addr[i], exp_data[i], exp_we_cyc[i]);
            end
        end
    endtask

    task automatic test_random();
        logic [7:0] a, dh, dl, cs, j;
        clear_logs();
        for (int f = 0; f < 40; f++) begin
            for (int k = $urandom_range(0, 2); k > 0; k--) begin
                j = 8'($urandom_range(0, 255));
                if (j == 8'hA5) j = 8'h00;
                send_byte(j, $urandom_range(0, 3));
            end
            a  = ($urandom_range(0, 5) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 5));
            dh = ($urandom_range(0, 3) == 0) ? 8'hA5 : 8'($urandom_range(0, 255));
            dl = 8'($urandom_range(0, 255));
            cs = a ^ dh ^ dl;
            if ($urandom_range(0, 3) == 0) cs = cs ^ 8'(1 << $urandom_range(0, 7));
            send_frame(8'hA5, a, dh, dl, cs, $urandom_range(0, 3));
        end
        idle(3);
        total++;
        if (mon_we_cyc.size() != exp_we_cyc.size() || mon_err_cyc.size() != exp_err_cyc.size()) begin
            bad++; $display("FAIL rand_count: got we=%0d err=%0d want %0d %0d", mon_we_cyc.size(),
                            mon_err_cyc.size(), exp_we_cyc.size(), exp_err_cyc.size());
        end
        for (int i = 0; i < exp_we_cyc.size() && i < mon_we_cyc.size(); i++) begin
            total++;
            if ({mon_addr[i], mon_data[i], mon_we_cyc[i]} !== {exp_addr[i], exp_data[i], exp_we_cyc[i]}) begin
                bad++; $display("FAIL rand_write%0d: got %h/%h@%0d want %h/%h@%0d", i,
                                mon_addr[i], mon_data[i], mon_we_cyc[i], exp_addr[i], exp_data[i], exp_we_cyc[i]);
            end
        end
        for (int i = 0; i < exp_err_cyc.size() && i < mon_err_cyc.size(); i++) begin
            total++;
            if (mon_err_cyc[i] != exp_err_cyc[i]) begin
                bad++; $display("FAIL rand_err%0d: got cycle %0d want %0d", i, mon_err_cyc[i], exp_err_cyc[i]);
            end
        end
        total++;
        if (bus.err_cnt !== 8'(exp_cnt())) begin
            bad++; $display("FAIL rand_cnt: got %0d want %0d", bus.err_cnt, exp_cnt());
        end
        total++;
        if (both_seen || ready_bad) begin
            bad++; $display("FAIL rand_exclusive: got both=%0d ready_bad=%0d want 0 0", both_seen, ready_bad);
        end
    endtask

    task automatic test_reset_mid_frame();
        clear_logs();
        send_byte(8'hA5, 0);
        send_byte(8'h02, 0);
        send_byte(8'h00, 0);
        rst = 1'b0;
        #1;
        total++;
        if ({bus.rx_ready, bus.cfg_we, bus.cfg_addr, bus.wght_data, bus.frame_err, bus.err_cnt, bus.busy}
            !== {1'b1, 1'b0, 4'h0, 16'h0000, 1'b0, 8'h00, 1'b0}) begin
            bad++;
            $display("FAIL midrst_state: rdy=%b we=%b addr=%h data=%h err=%b cnt=%0d busy=%b want 1 0 0 0000 0 0 0",
                     bus.rx_ready, bus.cfg_we, bus.cfg_addr, bus.wght_data, bus.frame_err, bus.err_cnt, bus.busy);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        fb.delete();
        exp_errs = 0;
        idle(4);
        total++;
        if (mon_we_cyc.size() != 0 || mon_err_cyc.size() != 0) begin
            bad++; $display("FAIL midrst_quiet: got we=%0d err=%0d want 0 0", mon_we_cyc.size(), mon_err_cyc.size());
        end
        send_frame(8'hA5, 8'h01, 8'hAB, 8'hCD, 8'h67, 0);
        idle(3);
        total++;
        if (mon_we_cyc.size() != 1 || {bus.cfg_addr, bus.wght_data, bus.err_cnt} !== {4'h1, 16'hABCD, 8'h00}) begin
            bad++; $display("FAIL midrst_recover: got we=%0d addr=%h data=%h cnt=%0d want 1 1 abcd 0",
                            mon_we_cyc.size(), bus.cfg_addr, bus.wght_data, bus.err_cnt);
        end
    endtask

    task automatic test_saturation();
        clear_logs();
        for (int i = 0; i < 255; i++) send_frame(8'hA5, 8'h00, 8'h00, 8'h00, 8'h01, 0);
        idle(2);
        total++;
        if (bus.err_cnt !== 8'(exp_cnt())) begin
            bad++; $display("FAIL sat_reach: got %0d want %0d", bus.err_cnt, exp_cnt());
        end
        send_frame(8'hA5, 8'h00, 8'h00, 8'h00, 8'h01, 0);
        send_frame(8'hA5, 8'h07, 8'h00, 8'h00, 8'h07, 0);
        idle(2);
        total++;
        if (bus.err_cnt !== 8'(exp_cnt()) || mon_err_cyc.size() != exp_err_cyc.size()) begin
            bad++; $display("FAIL sat_hold: got cnt=%0d pulses=%0d want %0d %0d",
                            bus.err_cnt, mon_err_cyc.size(), exp_cnt(), exp_err_cyc.size());
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        rst = 1'b0;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        @(negedge clk);
        test_reset();
        test_good_frame();
        test_bad_csum();
        test_bad_addr();
        test_junk();
        test_timeout();
        test_back_to_back();
        test_random();
        test_reset_mid_frame();
        test_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
